// File: rtl/bdi_pkg.sv
// Shared base-delta-immediate definitions: encodings, payload sizes, segment counts, packer FSM states.
package bdi_pkg;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned SEG_W  = 32;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned ENC_W  = 3;
  localparam int unsigned NSEG_W = 4;
  localparam int unsigned BEAT_W = 3;

  typedef logic [ENC_W-1:0] enc_t;

  localparam enc_t ENC_RAW  = 3'd0;
  localparam enc_t ENC_B8D1 = 3'd1;
  localparam enc_t ENC_B8D2 = 3'd2;
  localparam enc_t ENC_B8D4 = 3'd3;
  localparam enc_t ENC_B4D1 = 3'd4;
  localparam enc_t ENC_B4D2 = 3'd5;
  localparam enc_t ENC_B2D1 = 3'd6;
  localparam enc_t ENC_ZERO = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Header word layout; total width equals SEG_W
  typedef struct packed {
    logic [15:0]       rsvd;
    logic [ID_W-1:0]   id;
    logic [NSEG_W-1:0] nseg;
    logic              pad;
    enc_t              enc;
  } hdr_t;

  function automatic int unsigned size_bits(enc_t enc);
    case (enc)
      ENC_RAW:  return 256;
      ENC_B8D1: return 96;
      ENC_B8D2: return 128;
      ENC_B8D4: return 192;
      ENC_B4D1: return 96;
      ENC_B4D2: return 160;
      ENC_B2D1: return 144;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [NSEG_W-1:0] nseg(enc_t enc);
    return NSEG_W'((size_bits(enc) + SEG_W - 1) / SEG_W);
  endfunction

  // Keeps only the payload bits of a beat that lie below the encoded size
  function automatic logic [SEG_W-1:0] beat_mask(enc_t enc, logic [BEAT_W-1:0] beat);
    logic [SEG_W-1:0] m;
    int unsigned base;
    base = SEG_W * 32'(beat);
    m = '0;
    for (int unsigned i = 0; i < SEG_W; i++) begin
      m[i] = (base + i) < size_bits(enc);
    end
    return m;
  endfunction

endpackage

// File: rtl/bdi_line_packer.sv
// Serialises one compressed line into a header word plus payload words, one line buffered.
// Optional feature macro: BDI_PACK_STATS_EN adds saturating line/word counters.
module bdi_line_packer
  import bdi_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ENC_W-1:0]  in_enc,
  input  logic [LINE_W-1:0] in_line,
  output logic              seg_valid,
  input  logic              seg_ready,
  output logic [SEG_W-1:0]  seg_data,
  output logic              seg_first,
`ifdef BDI_PACK_STATS_EN
  output logic [31:0]       stat_lines,
  output logic [31:0]       stat_words,
`endif
  output logic              seg_last
);

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  enc_t                enc_q, enc_d;
  logic [NSEG_W-1:0]   nseg_q, nseg_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                seg_valid_q, seg_valid_d;
  logic [SEG_W-1:0]    seg_data_q, seg_data_d;
  logic                seg_first_q, seg_first_d;
  logic                seg_last_q, seg_last_d;

  logic                seg_hs_c, line_done_c, accept_c, next_last_c;
  logic [BEAT_W-1:0]   next_beat_c;
  logic [SEG_W-1:0]    next_word_c;
  hdr_t                hdr_c;

  assign seg_hs_c    = seg_valid_q & seg_ready;
  assign line_done_c = seg_hs_c & seg_last_q;
  assign in_ready    = (state_q == ST_IDLE) | line_done_c;
  assign accept_c    = in_valid & in_ready;

  // Beat that follows the current segment: first payload word after the header
  assign next_beat_c = (state_q == ST_HDR) ? '0 : BEAT_W'(beat_q + BEAT_W'(1));
  assign next_word_c = SEG_W'(line_q >> (SEG_W * 32'(next_beat_c))) & beat_mask(enc_q, next_beat_c);
  assign next_last_c = (NSEG_W'(next_beat_c) + NSEG_W'(1)) == nseg_q;

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    enc_d       = enc_q;
    nseg_d      = nseg_q;
    beat_d      = beat_q;
    id_d        = id_q;
    seg_valid_d = seg_valid_q;
    seg_data_d  = seg_data_q;
    seg_first_d = seg_first_q;
    seg_last_d  = seg_last_q;

    if (state_q != ST_IDLE && seg_hs_c) begin
      if (seg_last_q) begin
        id_d        = id_q + ID_W'(1);
        state_d     = ST_IDLE;
        seg_valid_d = 1'b0;
        seg_data_d  = '0;
        seg_first_d = 1'b0;
        seg_last_d  = 1'b0;
      end else begin
        state_d     = ST_DATA;
        beat_d      = next_beat_c;
        seg_data_d  = next_word_c;
        seg_first_d = 1'b0;
        seg_last_d  = next_last_c;
      end
    end

    // Header uses the id after any completion in this same cycle
    hdr_c = '{rsvd: 16'h0, id: id_d, nseg: nseg(in_enc), pad: 1'b0, enc: in_enc};

    if (accept_c) begin
      state_d     = ST_HDR;
      line_d      = in_line;
      enc_d       = in_enc;
      nseg_d      = nseg(in_enc);
      beat_d      = '0;
      seg_valid_d = 1'b1;
      seg_data_d  = hdr_c;
      seg_first_d = 1'b1;
      seg_last_d  = (nseg(in_enc) == '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      line_q      <= '0;
      enc_q       <= '0;
      nseg_q      <= '0;
      beat_q      <= '0;
      id_q        <= '0;
      seg_valid_q <= 1'b0;
      seg_data_q  <= '0;
      seg_first_q <= 1'b0;
      seg_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      enc_q       <= enc_d;
      nseg_q      <= nseg_d;
      beat_q      <= beat_d;
      id_q        <= id_d;
      seg_valid_q <= seg_valid_d;
      seg_data_q  <= seg_data_d;
      seg_first_q <= seg_first_d;
      seg_last_q  <= seg_last_d;
    end
  end

  assign seg_valid = seg_valid_q;
  assign seg_data  = seg_data_q;
  assign seg_first = seg_first_q;
  assign seg_last  = seg_last_q;

`ifdef BDI_PACK_STATS_EN
  logic [31:0] stat_lines_q, stat_lines_d;
  logic [31:0] stat_words_q, stat_words_d;

  // Saturating activity counters
  always_comb begin
    stat_lines_d = stat_lines_q;
    stat_words_d = stat_words_q;
    if (line_done_c && stat_lines_q != '1) stat_lines_d = stat_lines_q + 32'd1;
    if (seg_hs_c && stat_words_q != '1)    stat_words_d = stat_words_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_lines_q <= '0;
      stat_words_q <= '0;
    end else begin
      stat_lines_q <= stat_lines_d;
      stat_words_q <= stat_words_d;
    end
  end

  assign stat_lines = stat_lines_q;
  assign stat_words = stat_words_q;
`endif

endmodule

// File: tb/tb_bdi_line_packer.sv
// Scoreboard bench for bdi_line_packer: stimulus pushes expected segments, a monitor pops on handshake.
module tb_bdi_line_packer;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_enc = 3'd0;
  logic [255:0] in_line = '0;
  logic         seg_valid;
  logic         seg_ready = 1'b1;
  logic [31:0]  seg_data;
  logic         seg_first;
  logic         seg_last;
`ifdef BDI_PACK_STATS_EN
  logic [31:0]  stat_lines;
  logic [31:0]  stat_words;
`endif

  bdi_line_packer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_enc    (in_enc),
    .in_line   (in_line),
    .seg_valid (seg_valid),
    .seg_ready (seg_ready),
    .seg_data  (seg_data),
    .seg_first (seg_first),
`ifdef BDI_PACK_STATS_EN
    .stat_lines(stat_lines),
    .stat_words(stat_words),
`endif
    .seg_last  (seg_last)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] d;
    logic        f;
    logic        l;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_id = 8'd0;
  bit         ready_mode = 1'b0;

  // Monitor state
  bit          stalled = 1'b0;
  logic [31:0] held_d;
  logic        held_f, held_l;
  exp_t        mon_e;

  function automatic int unsigned tb_size(input logic [2:0] e);
    case (e)
      3'd0: return 256;
      3'd1: return 96;
      3'd2: return 128;
      3'd3: return 192;
      3'd4: return 96;
      3'd5: return 160;
      3'd6: return 144;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic f, input logic l);
    exp_t e;
    e.d = d; e.f = f; e.l = l;
    sb_q.push_back(e);
  endtask

  // Reference model for one line: header then masked payload words
  task automatic push_line(input logic [2:0] enc, input logic [255:0] line);
    int unsigned size, n;
    logic [255:0] sh;
    logic [31:0]  w;
    size = tb_size(enc);
    n = (size + 31) / 32;
    push_exp({16'h0, exp_id, 4'(n), 1'b0, enc}, 1'b1, n == 0);
    for (int unsigned k = 0; k < n; k++) begin
      sh = line >> (k * 32);
      w  = sh[31:0];
      for (int unsigned i = 0; i < 32; i++) if (k * 32 + i >= size) w[i] = 1'b0;
      push_exp(w, 1'b0, k == n - 1);
    end
    exp_id++;
  endtask

  task automatic send(input logic [2:0] enc, input logic [255:0] line, input bit auto_exp);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_enc   = enc;
    in_line  = line;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual in_ready=0 required in_ready=1 enc=%0d", enc);
    end else if (auto_exp) begin
      push_line(enc, line);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_enc   = 3'($urandom);
    in_line  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 3000; n++) begin
      if (sb_q.size() == 0) break;
      @(negedge clock);
    end
    check(name, 32'(sb_q.size()), 32'd0);
    @(posedge clock); #1;
  endtask

  // Ready pattern: constant 1, or toggling every cycle
  initial begin
    forever begin
      @(posedge clock); #1;
      if (ready_mode) seg_ready = ~seg_ready;
      else            seg_ready = 1'b1;
    end
  end

  // Monitor: compares each handshaked segment and checks stall stability
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checks++;
          if (!seg_valid || seg_data !== held_d || seg_first !== held_f || seg_last !== held_l) begin
            failures++;
            $display("FAIL hold actual v=%b d=%h f=%b l=%b required v=1 d=%h f=%b l=%b",
                     seg_valid, seg_data, seg_first, seg_last, held_d, held_f, held_l);
          end
        end
        if (seg_valid && seg_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL extra_seg actual d=%h f=%b l=%b required no segment", seg_data, seg_first, seg_last);
          end else begin
            mon_e = sb_q.pop_front();
            if (seg_data !== mon_e.d || seg_first !== mon_e.f || seg_last !== mon_e.l) begin
              failures++;
              $display("FAIL seg_word actual d=%h f=%b l=%b required d=%h f=%b l=%b",
                       seg_data, seg_first, seg_last, mon_e.d, mon_e.f, mon_e.l);
            end
          end
        end
        stalled = seg_valid && !seg_ready;
        held_d  = seg_data;
        held_f  = seg_first;
        held_l  = seg_last;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] line;
    int           cnt;
    bit           found;

    // Power-up reset
    #1 reset_n = 1'b0;
    #2;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_seg_valid", 32'(seg_valid), 32'd0);
    check("rst_seg_data",  seg_data,       32'd0);
    check("rst_seg_first", 32'(seg_first), 32'd0);
    check("rst_seg_last",  32'(seg_last),  32'd0);
`ifdef BDI_PACK_STATS_EN
    check("rst_stat_lines", stat_lines, 32'd0);
    check("rst_stat_words", stat_words, 32'd0);
`endif
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // B8D1: header 0x31 then three 0xAAAAAAAA words, junk above bit 95 masked
    line = {8{32'h5A5A_5A5A}};
    line[95:0] = 96'hAAAAAAAA_AAAAAAAA_AAAAAAAA;
    push_exp(32'h0000_0031, 1'b1, 1'b0);
    push_exp(32'hAAAA_AAAA, 1'b0, 1'b0);
    push_exp(32'hAAAA_AAAA, 1'b0, 1'b0);
    push_exp(32'hAAAA_AAAA, 1'b0, 1'b1);
    exp_id++;
    send(3'd1, line, 1'b0);
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (in_ready) break;
      cnt++;
    end
    check("in_ready_low_cycles", 32'(cnt), 32'd3);
    wait_drain("drain_b8d1");

    // B2D1 all ones: last beat keeps only bits 143:128
    push_exp(32'h0000_0156, 1'b1, 1'b0);
    push_exp(32'hFFFF_FFFF, 1'b0, 1'b0);
    push_exp(32'hFFFF_FFFF, 1'b0, 1'b0);
    push_exp(32'hFFFF_FFFF, 1'b0, 1'b0);
    push_exp(32'hFFFF_FFFF, 1'b0, 1'b0);
    push_exp(32'h0000_FFFF, 1'b0, 1'b1);
    exp_id++;
    send(3'd6, '1, 1'b0);
    wait_drain("drain_b2d1");

    // Zero line then raw line back to back, no bubble between them
    for (int k = 0; k < 8; k++) line[k*32 +: 32] = 32'h1000_0000 + 32'(k);
    send(3'd7, {8{32'hDEAD_BEEF}}, 1'b1);
    send(3'd0, line, 1'b1);
    cnt = 0;
    for (int n = 0; n < 9; n++) begin
      @(negedge clock);
      if (seg_valid) cnt++;
    end
    check("no_bubble_valid_cycles", 32'(cnt), 32'd9);
    wait_drain("drain_zero_raw");

    // B8D4 under alternating back-pressure
    for (int k = 0; k < 8; k++) line[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
    ready_mode = 1'b1;
    send(3'd3, line, 1'b1);
    wait_drain("drain_b8d4_stall");
    ready_mode = 1'b0;
    @(posedge clock); #1;

    // Reset asserted while beat 2 of a B8D2 line is presented
    for (int k = 0; k < 8; k++) line[k*32 +: 32] = {4{8'(8'h11 * (k + 1))}};
    send(3'd2, line, 1'b1);
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (seg_valid && seg_data == 32'h3333_3333) begin found = 1'b1; break; end
    end
    check("beat2_seen", 32'(found), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_seg_valid", 32'(seg_valid), 32'd0);
    check("midrst_seg_data",  seg_data,       32'd0);
    check("midrst_seg_first", 32'(seg_first), 32'd0);
    check("midrst_seg_last",  32'(seg_last),  32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    sb_q.delete();
    exp_id = 8'd0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // First line after reset carries id 0
    line = {8{32'h0F0F_0F0F}};
    push_exp(32'h0000_0031, 1'b1, 1'b0);
    push_exp(32'h0F0F_0F0F, 1'b0, 1'b0);
    push_exp(32'h0F0F_0F0F, 1'b0, 1'b0);
    push_exp(32'h0F0F_0F0F, 1'b0, 1'b1);
    exp_id++;
    send(3'd1, line, 1'b0);
    wait_drain("drain_after_reset");

    // Fresh reset, then 256 B4D1 lines so the id wraps
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    sb_q.delete();
    exp_id = 8'd0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 256; i++) begin
      send(3'd4, {8{32'(i) * 32'h0101_0101}}, 1'b1);
    end
    wait_drain("drain_wrap");
`ifdef BDI_PACK_STATS_EN
    check("stat_lines_256",  stat_lines, 32'd256);
    check("stat_words_1024", stat_words, 32'd1024);
`endif
    push_exp(32'h0000_0034, 1'b1, 1'b0);
    push_exp(32'h7777_7777, 1'b0, 1'b0);
    push_exp(32'h7777_7777, 1'b0, 1'b0);
    push_exp(32'h7777_7777, 1'b0, 1'b1);
    exp_id++;
    send(3'd4, {8{32'h7777_7777}}, 1'b0);
    wait_drain("drain_wrapped_id0");

    check("sb_empty_end", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
